// File: rtl/bf16_simd_operand_issue.sv
// BF16 SIMD operand issue stage: maps per-lane sources onto FMA operands
// (A*B+C) by funct5, zeroes disabled lanes and illegal ops, and buffers
// the result behind a 2-entry valid/ready skid stage.
//
// state | meaning
// EMPTY | no operation buffered, outputs invalid
// ONE   | main register holds the head operation
// FULL  | main holds the head, skid holds the next one; in_ready low
module bf16_simd_operand_issue #(
  parameter int          LANES     = 2,
  parameter logic [15:0] ONE_BF16  = 16'h3F80,
  parameter logic [15:0] ZERO_BF16 = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [16*LANES-1:0] in1,
  input  logic [16*LANES-1:0] in2,
  input  logic [16*LANES-1:0] in3,
  input  logic [4:0]         funct5,
  input  logic [LANES-1:0]   lane_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [16*LANES-1:0] out1,
  output logic [16*LANES-1:0] out2,
  output logic [16*LANES-1:0] out3,
  output logic [4:0]         out_funct5,
  output logic [LANES-1:0]   out_lane_en,
  output logic               out_illegal
);

  localparam int W   = 16 * LANES;
  localparam int OPW = 3 * W + 5 + LANES + 1;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [1:0] K_ADD = 2'd0;
  localparam logic [1:0] K_MUL = 2'd1;
  localparam logic [1:0] K_FMA = 2'd2;
  localparam logic [1:0] K_ILL = 2'd3;

  logic [1:0]     state;
  logic [1:0]     state_next;
  logic [1:0]     kind;
  logic [W-1:0]   dec_a;
  logic [W-1:0]   dec_b;
  logic [W-1:0]   dec_c;
  logic           dec_illegal;
  logic [OPW-1:0] dec_op;
  logic [OPW-1:0] main_q;
  logic [OPW-1:0] skid_q;
  logic           accept;
  logic           pop;
  logic           load_main;
  logic           load_skid;
  logic           move_skid;

  // Combinational decode of the incoming operation into A/B/C per lane.
  always_comb begin
    case (funct5)
      5'b00000, 5'b00001: kind = K_ADD;
      5'b00010:           kind = K_MUL;
      5'b00100, 5'b00101: kind = K_FMA;
      default:            kind = K_ILL;
    endcase
    dec_illegal = (kind == K_ILL);
    dec_a = {LANES{ZERO_BF16}};
    dec_b = {LANES{ZERO_BF16}};
    dec_c = {LANES{ZERO_BF16}};
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i] && !dec_illegal) begin
        dec_a[16*i +: 16] = in1[16*i +: 16];
        case (kind)
          K_ADD: begin
            dec_b[16*i +: 16] = ONE_BF16;
            dec_c[16*i +: 16] = in2[16*i +: 16];
          end
          K_MUL: begin
            dec_b[16*i +: 16] = in2[16*i +: 16];
          end
          default: begin
            dec_b[16*i +: 16] = in2[16*i +: 16];
            dec_c[16*i +: 16] = in3[16*i +: 16];
          end
        endcase
      end
    end
    dec_op = {dec_illegal, lane_en, funct5, dec_c, dec_b, dec_a};
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Occupancy transitions on accept/pop.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = ONE;
      ONE: begin
        if (accept && !pop)      state_next = FULL;
        else if (pop && !accept) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Handshake and buffer-load controls from the current occupancy.
  always_comb begin
    in_ready  = !rst && (state != FULL);
    out_valid = (state != EMPTY);
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
    load_main = accept && ((state == EMPTY) || ((state == ONE) && pop));
    load_skid = accept && (state == ONE) && !pop;
    move_skid = pop && (state == FULL);
  end

  // Main and skid data registers; main always holds the FIFO head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)      main_q <= dec_op;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= dec_op;
    end
  end

  assign out1        = main_q[W-1:0];
  assign out2        = main_q[2*W-1:W];
  assign out3        = main_q[3*W-1:2*W];
  assign out_funct5  = main_q[3*W+4:3*W];
  assign out_lane_en = main_q[3*W+5+LANES-1:3*W+5];
  assign out_illegal = main_q[OPW-1];

endmodule

// File: tb/tb_bf16_simd_operand_issue.sv
// Self-checking bench for bf16_simd_operand_issue (LANES=2) against a
// queue-based reference model of the operand mapping and 2-deep buffer.
module tb_bf16_simd_operand_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1, in2, in3;
  logic [4:0]  funct5;
  logic [1:0]  lane_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out1, out2, out3;
  logic [4:0]  out_funct5;
  logic [1:0]  out_lane_en;
  logic        out_illegal;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [4:0]  f;
    logic [1:0]  en;
    logic        ill;
  } op_t;

  op_t q[$];

  bf16_simd_operand_issue #(.LANES(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .in3(in3),
    .funct5(funct5), .lane_en(lane_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .out2(out2), .out3(out3),
    .out_funct5(out_funct5), .out_lane_en(out_lane_en),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic op_t ref_op(logic [31:0] x1, logic [31:0] x2,
                                 logic [31:0] x3, logic [4:0] f,
                                 logic [1:0] en);
    op_t o;
    o = '0;
    o.f = f;
    o.en = en;
    o.ill = !(f inside {5'd0, 5'd1, 5'd2, 5'd4, 5'd5});
    for (int i = 0; i < 2; i++) begin
      if (!o.ill && en[i]) begin
        o.a[16*i +: 16] = x1[16*i +: 16];
        if (f <= 5'd1) begin
          o.b[16*i +: 16] = 16'h3F80;
          o.c[16*i +: 16] = x2[16*i +: 16];
        end else if (f == 5'd2) begin
          o.b[16*i +: 16] = x2[16*i +: 16];
        end else begin
          o.b[16*i +: 16] = x2[16*i +: 16];
          o.c[16*i +: 16] = x3[16*i +: 16];
        end
      end
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("out1", out1, q[0].a);
      chk("out2", out2, q[0].b);
      chk("out3", out3, q[0].c);
      chk("out_funct5", {27'd0, out_funct5}, {27'd0, q[0].f});
      chk("out_lane_en", {30'd0, out_lane_en}, {30'd0, q[0].en});
      chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
    end
  endtask

  // Called at a falling edge: drive handshake, advance one clock, check.
  task automatic cycle(input logic v, input logic r, output logic acc);
    logic pop;
    op_t  n;
    in_valid  = v;
    out_ready = r;
    pop = (q.size() != 0) && r;
    acc = v && (q.size() < 2);
    n = ref_op(in1, in2, in3, funct5, lane_en);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(n);
    @(negedge clk);
    check_state();
  endtask

  task automatic rand_ops();
    logic [4:0] legal [5];
    legal = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5};
    in1 = $urandom;
    in2 = $urandom;
    in3 = $urandom;
    lane_en = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) funct5 = 5'($urandom_range(0, 31));
    else                           funct5 = legal[$urandom_range(0, 4)];
  endtask

  initial begin
    logic acc;
    int   k;
    logic [31:0] ops1 [4];

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in1 = '0; in2 = '0; in3 = '0;
    funct5 = '0; lane_en = '0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out1", out1, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed opcode checks
    funct5 = 5'b00000; lane_en = 2'b11;
    in1 = 32'h4040BF80; in2 = 32'h3FC04000; in3 = 32'h12345678;
    cycle(1'b1, 1'b1, acc);
    chk("add_out1", out1, 32'h4040BF80);
    chk("add_out2", out2, 32'h3F803F80);
    chk("add_out3", out3, 32'h3FC04000);
    chk("add_ill", {31'd0, out_illegal}, 32'd0);

    funct5 = 5'b00010; in1 = 32'h40004040; in2 = 32'h40803F80; in3 = $urandom;
    cycle(1'b1, 1'b1, acc);
    chk("mul_out2", out2, 32'h40803F80);
    chk("mul_out3", out3, 32'h00000000);

    funct5 = 5'b00101;
    cycle(1'b1, 1'b1, acc);
    chk("fma_out3", out3, in3);

    funct5 = 5'b00011;
    cycle(1'b1, 1'b1, acc);
    chk("ill_out1", out1, 32'd0);
    chk("ill_out3", out3, 32'd0);
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);

    funct5 = 5'b00001;
    cycle(1'b1, 1'b1, acc);
    chk("sub_out2", out2, 32'h3F803F80);
    chk("sub_out3", out3, in2);

    funct5 = 5'b00100; lane_en = 2'b01;
    cycle(1'b1, 1'b1, acc);
    chk("lane_out1", out1, {16'h0000, in1[15:0]});
    chk("lane_out2", out2, {16'h0000, in2[15:0]});
    chk("lane_out3", out3, {16'h0000, in3[15:0]});
    chk("lane_en", {30'd0, out_lane_en}, 32'd1);
    cycle(1'b0, 1'b1, acc);

    // Back-to-back stream into a stalled consumer, then drain
    for (int i = 0; i < 4; i++) ops1[i] = 32'h00010001 * (i + 1);
    k = 0;
    funct5 = 5'b00100; lane_en = 2'b11;
    for (int t = 0; t < 40; t++) begin
      if (k < 4) begin
        in1 = ops1[k]; in2 = $urandom; in3 = $urandom;
      end
      cycle(k < 4, t >= 4, acc);
      if (acc) k++;
      if (k == 4 && q.size() == 0) break;
    end

    // Simultaneous accept and pop at occupancy one
    rand_ops();
    cycle(1'b1, 1'b0, acc);
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      cycle(1'b1, 1'b1, acc);
    end
    cycle(1'b0, 1'b1, acc);

    // Asynchronous reset while full
    rand_ops(); cycle(1'b1, 1'b0, acc);
    rand_ops(); cycle(1'b1, 1'b0, acc);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out1", out1, 32'd0);
    chk("arst_out2", out2, 32'd0);
    chk("arst_out3", out3, 32'd0);
    chk("arst_funct5", {27'd0, out_funct5}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_rel_out_valid", {31'd0, out_valid}, 32'd0);
    rand_ops();
    cycle(1'b1, 1'b0, acc);
    cycle(1'b0, 1'b1, acc);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
